mmio_pwm_leds: RTL
==================

MMIO_PWM_LEDS -- requirements
Module: mmio_pwm_leds

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0400, byte address of register block.
REQ-002 Parameter NUM_CH, default 4, number of PWM channels (1..8).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MemWrite  input  1  core store strobe, one cycle per store.
REQ-006 DataAdr  input  32  core byte address.
REQ-007 WriteData  input  32  core store data.
REQ-008 ReadData  output  32  combinational read of addressed register.
REQ-009 leds  output  4  LED register bits [3:0].
REQ-010 pwm_out  output  NUM_CH  registered PWM outputs, bit i = channel i.

Function
REQ-011 The block SHALL be selected when DataAdr[31:6] == BASE_ADDR[31:6]; the offset is DataAdr[5:0].
REQ-012 The register map (offset) SHALL be 0x00 LED[3:0], 0x04 PERIOD[15:0], 0x08 CTRL[0]=enable, and 0x10+4*i DUTY_i[15:0] for i<NUM_CH.
REQ-013 A write SHALL occur when MemWrite=1, the block is selected, the offset is mapped, and DataAdr[1:0]==0; all other writes SHALL be ignored with no state change.
REQ-014 Written values SHALL be truncated to the field width and be visible on ReadData and outputs from the next rising edge.
REQ-015 ReadData SHALL return the zero-extended field for mapped offsets, and 0 for unmapped, misaligned, or unselected addresses.
REQ-016 DUTY_i SHALL be a shadow register; active_duty_i SHALL load from DUTY_i when cnt wraps to 0, and on every cycle while enable=0.
REQ-017 A 16-bit counter cnt SHALL increment each cycle while enable=1 and PERIOD!=0, wrapping from cnt>=PERIOD to 0, giving a period of PERIOD+1 cycles.
REQ-018 If PERIOD is written below the current cnt, cnt SHALL wrap to 0 on the next edge, with no out-of-range count.
REQ-019 When enable=0 or PERIOD==0, cnt SHALL be held at 0 and all pwm_out bits SHALL be 0 on the next edge.
REQ-020 pwm_out[i] SHALL be registered: next value = enable && PERIOD!=0 && (cnt < active_duty_i).
REQ-021 Consequences of REQ-020: active_duty_i==0 gives a constant low output, and active_duty_i>PERIOD gives a constant high output.
REQ-022 Setting enable from 0 to 1 SHALL start with cnt=0; the first pwm_out high, if any, SHALL appear one edge later.
REQ-023 leds SHALL drive LED[3:0] directly from the register, with no dependence on enable.
REQ-024 A write to CTRL and a wrap in the same cycle SHALL both take effect; the wrap load of active_duty uses the pre-write DUTY value.
REQ-025 A write to DUTY_i in the same cycle as the wrap SHALL NOT load into active_duty_i; it SHALL load at the following wrap.

Reset
REQ-026 Asserting reset low SHALL immediately clear LED, PERIOD, CTRL, all DUTY_i, all active_duty_i, cnt, and pwm_out to 0, and ReadData of mapped registers SHALL read 0.
REQ-027 Reset mid-period SHALL abort the cycle; after release the block SHALL be idle until software re-enables it.
REQ-028 Release SHALL be taken on the first rising edge after reset goes high; no write is accepted while reset is low.

Verification
REQ-029 Scenario: write LED=0xFFFF_FFF5 at 0x400 -> leds=4'b0101 next cycle, and ReadData at 0x400 = 0x5.
REQ-030 Scenario: PERIOD=9, DUTY_0=3, enable=1 -> pwm_out[0] is high for 3 cycles then low for 7, repeating every 10 cycles.
REQ-031 Scenario: while running with DUTY_0=3, write DUTY_0=7 mid-period -> current period keeps 3 high cycles, and the next period has 7.
REQ-032 Scenario: DUTY_1=0 and DUTY_2=20 with PERIOD=9 -> pwm_out[1] constantly 0 and pwm_out[2] constantly 1 while enabled.
REQ-033 Scenario: misaligned write to 0x405 and write to unmapped 0x40C -> no register changes, and ReadData at 0x40C = 0.
REQ-034 Scenario: assert reset low mid-period -> pwm_out, leds, and cnt are 0 without waiting for a clock edge, and all registers read 0 after release.

Source files
------------

// File: rtl/mmio_pwm_leds.sv
// rtl/mmio_pwm_leds.sv - memory-mapped LED register and multi-channel PWM block
module mmio_pwm_leds #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          NUM_CH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       DataAdr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic [3:0]        leds,
  output logic [NUM_CH-1:0] pwm_out
);

  // Duty registers occupy word slots 4 .. 4+NUM_CH-1 of the 64-byte window.
  localparam logic [4:0] DUTY_FIRST = 5'd4;
  localparam logic [4:0] DUTY_END   = 5'(4 + NUM_CH);

  logic [3:0]  r_led;
  logic [15:0] r_period;
  logic        r_enable;
  logic [15:0] r_cnt;
  logic [15:0] r_duty   [NUM_CH];
  logic [15:0] r_active [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;

  logic              w_sel;
  logic              w_aligned;
  logic [5:0]        w_off;
  logic              w_hit_led;
  logic              w_hit_per;
  logic              w_hit_ctrl;
  logic              w_hit_duty;
  logic [3:0]        w_duty_idx;
  logic [NUM_CH-1:0] w_duty_sel;
  logic [NUM_CH-1:0] w_duty_we;
  logic              w_we_led;
  logic              w_we_per;
  logic              w_we_ctrl;
  logic              w_run;
  logic              w_wrap;
  logic              w_unused;

  // Store data above the widest field is deliberately dropped.
  assign w_unused = &{1'b0, WriteData[31:16]};

  assign w_sel      = (DataAdr[31:6] == BASE_ADDR[31:6]);
  assign w_off      = DataAdr[5:0];
  assign w_aligned  = (DataAdr[1:0] == 2'b00);
  assign w_hit_led  = w_sel && (w_off == 6'h00);
  assign w_hit_per  = w_sel && (w_off == 6'h04);
  assign w_hit_ctrl = w_sel && (w_off == 6'h08);
  assign w_hit_duty = w_sel && w_aligned &&
                      ({1'b0, w_off[5:2]} >= DUTY_FIRST) &&
                      ({1'b0, w_off[5:2]} <  DUTY_END);
  assign w_duty_idx = w_off[5:2] - 4'd4;

  assign w_we_led  = MemWrite && w_hit_led;
  assign w_we_per  = MemWrite && w_hit_per;
  assign w_we_ctrl = MemWrite && w_hit_ctrl;

  // Counting is only meaningful with a nonzero period; wrap when cnt reaches
  // or overshoots PERIOD so a shrinking period never leaves cnt out of range.
  assign w_run  = r_enable && (r_period != 16'd0);
  assign w_wrap = w_run && (r_cnt >= r_period);

  // Per-channel select and write strobes for the duty shadow registers.
  always_comb begin
    w_duty_sel = '0;
    w_duty_we  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_duty_sel[i] = w_hit_duty && (w_duty_idx == 4'(i));
      w_duty_we[i]  = MemWrite && w_duty_sel[i];
    end
  end

  // Combinational read mux; anything not decoded reads as zero.
  always_comb begin
    ReadData = 32'd0;
    if (w_hit_led) begin
      ReadData = {28'd0, r_led};
    end else if (w_hit_per) begin
      ReadData = {16'd0, r_period};
    end else if (w_hit_ctrl) begin
      ReadData = {31'd0, r_enable};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_duty_sel[i]) begin
          ReadData = {16'd0, r_duty[i]};
        end
      end
    end
  end

  // Software-visible control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led    <= 4'd0;
      r_period <= 16'd0;
      r_enable <= 1'b0;
    end else begin
      if (w_we_led)  r_led    <= WriteData[3:0];
      if (w_we_per)  r_period <= WriteData[15:0];
      if (w_we_ctrl) r_enable <= WriteData[0];
    end
  end

  // Duty shadow registers, written by software at any time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) r_duty[i] <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_duty_we[i]) r_duty[i] <= WriteData[15:0];
      end
    end
  end

  // Active duty follows the shadow at each wrap (glitch-free updates) and
  // tracks it continuously while disabled so enabling starts with fresh values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) r_active[i] <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wrap || !r_enable) r_active[i] <= r_duty[i];
      end
    end
  end

  // Period counter: held at zero when idle, PERIOD+1 cycles per period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= 16'd0;
    end else if (!w_run || w_wrap) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Registered PWM compare against the active duty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_pwm[i] <= w_run && (r_cnt < r_active[i]);
      end
    end
  end

  assign leds    = r_led;
  assign pwm_out = r_pwm;

endmodule
